display_arbiter: RTL and testbench
==================================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, CLK cycles per 1 ms tick (50 MHz clock).
REQ-002 SHALL have parameter HOLD_MS, default 1000, minimum grant duration in ticks, range 1..65535.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_a  input  1  requester A (counter source) wants the display.
REQ-006 SHALL have port a_bcd  input  12  requester A digits {hundreds, tens, units}, 4 bits each.
REQ-007 SHALL have port req_b  input  1  requester B (message source) wants the display.
REQ-008 SHALL have port b_bcd  input  12  requester B digits, same packing as a_bcd.
REQ-009 SHALL have ports gnt_a, gnt_b  output  1 each  display granted to A / B.
REQ-010 SHALL have ports units, tens, hundreds  output  4 each  registered digit codes to the 7-segment multiplexer.

Function
REQ-011 SHALL run a free-running tick counter 0..TICK_DIV-1 and pulse tick for one cycle when the count equals TICK_DIV-1, then wrap to 0.
REQ-012 SHALL implement states IDLE, GRANT_A, GRANT_B; gnt_a is high only in GRANT_A, gnt_b only in GRANT_B, never both.
REQ-013 SHALL keep a hold counter, cleared on every state entry, incremented on tick, saturating at HOLD_MS; hold_done is high when it equals HOLD_MS.
REQ-014 SHALL transition IDLE -> GRANT_A when only req_a is high, IDLE -> GRANT_B when only req_b is high, and remain in IDLE when neither is high.
REQ-015 SHALL, when req_a and req_b are high together in IDLE, grant the requester not served last (last_served register).
REQ-016 SHALL, in GRANT_x with hold_done high and the other requester high, move directly to the other GRANT state, even if req_x is still high (round-robin time slicing).
REQ-017 SHALL, in GRANT_x with hold_done high, the other requester low and req_x low, return to IDLE.
REQ-018 SHALL otherwise remain in GRANT_x; deasserting req_x before hold_done does not end the grant early.
REQ-019 SHALL update last_served on every entry to a GRANT state.
REQ-020 SHALL load units/tens/hundreds every clock edge from the BCD input of the requester granted by the current state (one-cycle latency); in IDLE it loads 0,0,0.
REQ-021 SHALL pass digit codes 4'hA..4'hF through unmodified; no arithmetic is performed on them.

Reset
REQ-022 SHALL, while RESET is high, hold state IDLE, the tick counter and hold counter at 0, last_served = B (so A wins the first tie), gnt_a = gnt_b = 0, and units = tens = hundreds = 0.
REQ-023 SHALL, on RESET asserted mid-grant, drop the grant immediately (asynchronously) and restart arbitration from IDLE on the first clock edge after release.

Configuration
REQ-024 SHALL, with macro DISPLAY_ARB_BLANK_EN defined, apply leading-zero blanking to the loaded digits: hundreds becomes 4'hF (blank code) when 0; tens becomes 4'hF when hundreds and tens are both 0; units is never blanked (IDLE shows F,F,0).
REQ-025 SHALL, without DISPLAY_ARB_BLANK_EN, load digits unmodified per REQ-020.

Verification (bench parameters TICK_DIV=4, HOLD_MS=3)
REQ-026 SHALL cover reset: RESET high with req_a=1 -> gnt_a=gnt_b=0, digits 0,0,0; RESET low -> gnt_a=1 on the next edge; digits = a_bcd one cycle after that.
REQ-027 SHALL cover tie: req_a=req_b=1 from IDLE after reset -> GRANT_A; after 3 ticks -> GRANT_B; after 3 more ticks -> GRANT_A.
REQ-028 SHALL cover minimum hold: req_b pulsed for 1 cycle with b_bcd=12'h123 -> gnt_b high for 3 ticks (about 12 cycles), digits 1,2,3, then IDLE with digits 0,0,0.
REQ-029 SHALL cover sole requester: req_a held high alone for 20 ticks -> gnt_a stays high throughout, digits track a_bcd changes with one-cycle latency.
REQ-030 SHALL cover mid-grant reset: RESET pulsed in GRANT_B -> gnt_b low without waiting for a clock edge; after release with req_a=req_b=1 -> GRANT_A.
REQ-031 SHALL cover blanking: with DISPLAY_ARB_BLANK_EN defined and a_bcd=12'h007 granted -> F,F,7; with a_bcd=12'h040 -> F,4,0.

Source files
------------

// File: rtl/display_arbiter.sv
// Two-requester display arbiter: grants the 7-segment display to A or B with a minimum hold time in ms ticks and round-robin on contention.
// Latency: grant one edge after request; digits one edge after grant. Optional leading-zero blanking with DISPLAY_ARB_BLANK_EN.
module display_arbiter #(
    parameter int TICK_DIV = 50000,
    parameter int HOLD_MS  = 1000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_a,
    input  logic [11:0] a_bcd,
    input  logic        req_b,
    input  logic [11:0] b_bcd,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [3:0]  units,
    output logic [3:0]  tens,
    output logic [3:0]  hundreds
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] tick_cnt_q, tick_cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic        last_b_q, last_b_d;
    logic [11:0] digits_q, digits_d;
    logic        tick;
    logic        hold_done;
    logic [11:0] sel_bcd;

    assign tick      = (tick_cnt_q == CW'(TICK_DIV - 1));
    assign hold_done = (hold_q == HW'(HOLD_MS));

    // State register and all other flops
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            hold_q     <= '0;
            last_b_q   <= 1'b1;
            digits_q   <= '0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            hold_q     <= hold_d;
            last_b_q   <= last_b_d;
            digits_q   <= digits_d;
        end
    end

    // Next-state logic; on a tie in IDLE the requester not served last wins
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_a && req_b)
                    state_d = last_b_q ? GRANT_A : GRANT_B;
                else if (req_a)
                    state_d = GRANT_A;
                else if (req_b)
                    state_d = GRANT_B;
            end
            GRANT_A: begin
                if (hold_done) begin
                    if (req_b)
                        state_d = GRANT_B;
                    else if (!req_a)
                        state_d = IDLE;
                end
            end
            GRANT_B: begin
                if (hold_done) begin
                    if (req_a)
                        state_d = GRANT_A;
                    else if (!req_b)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        gnt_a = (state_q == GRANT_A);
        gnt_b = (state_q == GRANT_B);
    end

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        hold_d = hold_q;
        if (state_d != state_q)
            hold_d = '0;
        else if (tick && !hold_done)
            hold_d = hold_q + 1'b1;

        last_b_d = last_b_q;
        if (state_d != state_q) begin
            if (state_d == GRANT_A)
                last_b_d = 1'b0;
            else if (state_d == GRANT_B)
                last_b_d = 1'b1;
        end
    end

    // Digits follow the owner of the current state, one edge behind
    always_comb begin
        sel_bcd = 12'h000;
        if (state_q == GRANT_A)
            sel_bcd = a_bcd;
        else if (state_q == GRANT_B)
            sel_bcd = b_bcd;
`ifdef DISPLAY_ARB_BLANK_EN
        digits_d = sel_bcd;
        if (sel_bcd[11:8] == 4'h0) begin
            digits_d[11:8] = 4'hF;
            if (sel_bcd[7:4] == 4'h0)
                digits_d[7:4] = 4'hF;
        end
`else
        digits_d = sel_bcd;
`endif
    end

    assign hundreds = digits_q[11:8];
    assign tens     = digits_q[7:4];
    assign units    = digits_q[3:0];

endmodule

// File: tb/tb_display_arbiter.sv
// Scoreboard bench for display_arbiter with a cycle-level reference model of the arbitration rules.
// Build with DISPLAY_ARB_BLANK_EN to exercise the blanking variant; the model follows the same macro.
module tb_display_arbiter;

    localparam int TD   = 4;
    localparam int HOLD = 3;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req_a, req_b;
    logic [11:0] a_bcd, b_bcd;
    logic        gnt_a, gnt_b;
    logic [3:0]  units, tens, hundreds;

    display_arbiter #(.TICK_DIV(TD), .HOLD_MS(HOLD)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_a(req_a), .a_bcd(a_bcd),
        .req_b(req_b), .b_bcd(b_bcd),
        .gnt_a(gnt_a), .gnt_b(gnt_b),
        .units(units), .tens(tens), .hundreds(hundreds)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [13:0] exp_q[$];

    // Reference model: owner 0=none 1=A 2=B; slice counts ms ticks in the current grant
    int          m_owner, m_slice, m_cyc, m_last;
    logic [11:0] m_dig;
    logic        s_rst, s_ra, s_rb;
    logic [11:0] s_a, s_b;

    function automatic logic [11:0] fmt(input logic [11:0] v);
        logic [11:0] r;
        r = v;
`ifdef DISPLAY_ARB_BLANK_EN
        if (v / 256 == 0) begin
            r = r | 12'hF00;
            if ((v / 16) % 16 == 0) r = r | 12'h0F0;
        end
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_slice = 0; m_cyc = 0; m_last = 2; m_dig = 12'h000;
    endtask

    task automatic model_step();
        bit tick, done;
        int nxt;
        if (s_rst) begin
            model_reset();
            return;
        end
        tick = (m_cyc % TD) == TD - 1;
        m_cyc++;
        done = (m_slice == HOLD);
        m_dig = (m_owner == 1) ? fmt(s_a) : (m_owner == 2) ? fmt(s_b) : fmt(12'h000);
        nxt = m_owner;
        if (m_owner == 0)
            nxt = (s_ra && s_rb) ? (m_last == 2 ? 1 : 2) : s_ra ? 1 : s_rb ? 2 : 0;
        else if (done) begin
            if (m_owner == 1) nxt = s_rb ? 2 : (s_ra ? 1 : 0);
            else              nxt = s_ra ? 1 : (s_rb ? 2 : 0);
        end
        if (nxt != m_owner) begin
            m_slice = 0;
            if (nxt != 0) m_last = nxt;
        end else if (tick && m_slice < HOLD)
            m_slice++;
        m_owner = nxt;
    endtask

    // One clock: update model for the edge just taken, then apply the next inputs
    task automatic cyc(input logic ra, input logic [11:0] a, input logic rb,
                       input logic [11:0] b, input logic rst);
        @(posedge CLK);
        #1;
        model_step();
        RESET = rst; req_a = ra; a_bcd = a; req_b = rb; b_bcd = b;
        if (rst) model_reset();
        exp_q.push_back({m_owner == 1, m_owner == 2, m_dig});
        s_rst = rst; s_ra = ra; s_a = a; s_rb = rb; s_b = b;
    endtask

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: every negedge the DUT presents a new output word
    initial begin
        logic [13:0] e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard", {gnt_a, gnt_b, hundreds, tens, units}, e);
            end
        end
    end

    initial begin
        logic [11:0] ra_v, rb_v;
        logic        qa, qb;
        RESET = 1'b1; req_a = 1'b1; req_b = 1'b0; a_bcd = 12'h456; b_bcd = 12'h000;
        s_rst = 1'b1; s_ra = 1'b1; s_rb = 1'b0; s_a = 12'h456; s_b = 12'h000;
        model_reset();

        // Reset with req_a held, then release
        repeat (3) cyc(1, 12'h456, 0, 12'h000, 1);
        check("reset_outputs", {gnt_a, gnt_b, hundreds, tens, units}, 14'h0);
        cyc(1, 12'h456, 0, 12'h000, 0);
        cyc(1, 12'h456, 0, 12'h000, 0);
        check("first_grant_a", {12'h0, gnt_a, gnt_b}, 14'h2);
        repeat (5) cyc(1, 12'h456, 0, 12'h000, 0);

        // Tie from reset: A, then B, then A again
        repeat (2) cyc(1, 12'h111, 1, 12'h222, 1);
        repeat (40) cyc(1, 12'h111, 1, 12'h222, 0);

        // Drain, then a one-cycle B pulse must hold for the minimum time
        repeat (20) cyc(0, 12'h000, 0, 12'h000, 0);
        cyc(0, 12'h000, 1, 12'h123, 0);
        repeat (25) cyc(0, 12'h000, 0, 12'h123, 0);

        // Sole requester A for 20 ticks with changing digits, including A..F codes
        repeat (80) cyc(1, 12'($urandom), 0, 12'($urandom), 0);

        // Blanking patterns
        repeat (20) cyc(0, 12'h007, 0, 12'h000, 0);
        repeat (6) cyc(1, 12'h007, 0, 12'h000, 0);
        repeat (6) cyc(1, 12'h040, 0, 12'h000, 0);
        repeat (6) cyc(1, 12'h000, 0, 12'h000, 0);
        repeat (20) cyc(0, 12'h000, 0, 12'h000, 0);

        // Mid-grant reset in GRANT_B
        cyc(0, 12'h000, 1, 12'h987, 0);
        repeat (5) cyc(0, 12'h000, 1, 12'h987, 0);
        check("in_grant_b", {12'h0, gnt_a, gnt_b}, 14'h1);
        cyc(1, 12'h555, 1, 12'h987, 1);
        #1;
        check("async_drop", {12'h0, gnt_a, gnt_b}, 14'h0);
        cyc(1, 12'h555, 1, 12'h987, 1);
        cyc(1, 12'h555, 1, 12'h987, 0);
        cyc(1, 12'h555, 1, 12'h987, 0);
        check("post_reset_tie_a", {12'h0, gnt_a, gnt_b}, 14'h2);
        repeat (10) cyc(1, 12'h555, 1, 12'h987, 0);

        // Random traffic with occasional resets
        qa = 1'b0; qb = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) qa = ~qa;
            if ($urandom_range(0, 7) == 0) qb = ~qb;
            ra_v = 12'($urandom);
            rb_v = 12'($urandom);
            cyc(qa, ra_v, qb, rb_v, $urandom_range(0, 199) == 0);
        end
        cyc(0, 12'h000, 0, 12'h000, 0);

        @(negedge CLK);
        @(negedge CLK);
        check("queue_drained", 14'(exp_q.size()), 14'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
